sha_run_ctrl: RTL

SHA_RUN_CTRL -- requirements
Module: sha_run_ctrl

---
 rtl/sha_run_ctrl_if.sv | 30 +++
 rtl/sha_run_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/sha_run_ctrl_if.sv
// Bundle between the SHA run controller and its cores/host.
// The controller takes the master modport; the cores and host side take the slave modport.
interface sha_run_ctrl_if #(
    parameter int unsigned N_CORES = 4,
    parameter int unsigned CNT_W   = 16
);
    logic               go;
    logic               abort;
    logic [N_CORES-1:0] core_ready;
    logic [N_CORES-1:0] core_valid;
    logic [N_CORES-1:0] core_found;
    logic [N_CORES-1:0] core_start;
    logic               busy;
    logic               done;
    logic               pass;
    logic [N_CORES-1:0] fail_mask;
    logic               timeout;
    logic [CNT_W-1:0]   latency_max;
    logic [7:0]         runs_done;

    modport master (
        input  go, abort, core_ready, core_valid, core_found,
        output core_start, busy, done, pass, fail_mask, timeout, latency_max, runs_done
    );

    modport slave (
        output go, abort, core_ready, core_valid, core_found,
        input  core_start, busy, done, pass, fail_mask, timeout, latency_max, runs_done
    );
endinterface

// File: rtl/sha_run_ctrl.sv
// Session sequencer for N parallel SHA cores: waits for ready, starts all cores,
// collects first digest_valid per core with latency/timeout tracking, repeats RUNS times.
module sha_run_ctrl #(
    parameter int unsigned N_CORES     = 4,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TIMEOUT     = 1000,
    parameter int unsigned RUNS        = 1,
    parameter bit          PULSE_START = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    sha_run_ctrl_if.master bus
);

    localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [7:0]       RUNS_L  = 8'(RUNS);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_READY,
        START,
        WAIT_VALID,
        CHECK,
        DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [N_CORES-1:0] seen;

    logic [N_CORES-1:0] new_valid;
    logic [N_CORES-1:0] new_fail;
    logic [N_CORES-1:0] seen_nxt;
    logic               all_seen;
    logic               lat_upd;
    logic [CNT_W-1:0]   cnt_inc;

    // First valid per core only; a valid arriving with the timeout still counts.
    assign new_valid = bus.core_valid & ~seen;
    assign new_fail  = new_valid & ~bus.core_found;
    assign seen_nxt  = seen | new_valid;
    assign all_seen  = &seen_nxt;
    assign lat_upd   = (|new_valid) && (cnt > bus.latency_max);
    assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

    // cnt is 0 during START, so in WAIT_VALID it equals cycles since start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            seen            <= '0;
            bus.core_start  <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.pass        <= 1'b0;
            bus.fail_mask   <= '0;
            bus.timeout     <= 1'b0;
            bus.latency_max <= '0;
            bus.runs_done   <= '0;
        end else begin
            bus.done <= 1'b0;
            if (bus.abort) begin
                state          <= IDLE;
                bus.core_start <= '0;
                bus.busy       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.go) begin
                            state           <= WAIT_READY;
                            bus.busy        <= 1'b1;
                            cnt             <= '0;
                            bus.pass        <= 1'b0;
                            bus.fail_mask   <= '0;
                            bus.timeout     <= 1'b0;
                            bus.latency_max <= '0;
                            bus.runs_done   <= '0;
                        end
                    end
                    WAIT_READY: begin
                        if (&bus.core_ready) begin
                            state          <= START;
                            cnt            <= '0;
                            seen           <= '0;
                            bus.core_start <= '1;
                        end else if (cnt == TMO) begin
                            state         <= DONE;
                            bus.timeout   <= 1'b1;
                            bus.fail_mask <= ~bus.core_ready;
                            bus.pass      <= 1'b0;
                            bus.done      <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    START: begin
                        state <= WAIT_VALID;
                        cnt   <= cnt_inc;
                        if (PULSE_START) bus.core_start <= '0;
                    end
                    WAIT_VALID: begin
                        seen          <= seen_nxt;
                        bus.fail_mask <= bus.fail_mask | new_fail;
                        if (lat_upd) bus.latency_max <= cnt;
                        bus.core_start <= PULSE_START ? '0 : (bus.core_start & ~new_valid);
                        if (all_seen) begin
                            state <= CHECK;
                        end else if (cnt == TMO) begin
                            state          <= DONE;
                            bus.timeout    <= 1'b1;
                            bus.fail_mask  <= bus.fail_mask | new_fail | ~seen_nxt;
                            bus.core_start <= '0;
                            bus.pass       <= 1'b0;
                            bus.done       <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    CHECK: begin
                        bus.runs_done <= bus.runs_done + 8'd1;
                        if ((bus.runs_done + 8'd1 == RUNS_L) || (bus.fail_mask != '0)) begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                            bus.pass <= (bus.fail_mask == '0) && !bus.timeout;
                        end else begin
                            state <= WAIT_READY;
                            cnt   <= '0;
                        end
                    end
                    DONE: begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
